ifu_pc_gen: RTL

//  Fetch PC generator, directly upstream of IF_0. Holds the architectural fetch PC

---
 rtl/ifu_pc_gen_pkg.sv | 20 ++
 rtl/ifu_pc_gen_tracker.sv | 66 ++++++
 rtl/ifu_pc_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/ifu_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator.
//   PCG_RESET_PC        : fetch PC loaded on reset
//   PCG_MAX_OUTSTANDING : default cap on accepted-but-unanswered I-cache requests
//   pcgen_state_t       : request FSM states
//   npc_sel_t           : next-PC source select
package ifu_pc_gen_pkg;

  localparam logic [31:0] PCG_RESET_PC        = 32'hBFC0_0000;
  localparam int unsigned PCG_MAX_OUTSTANDING = 2;

  typedef enum logic [1:0] {PCG_BOOT, PCG_RUN, PCG_HOLD} pcgen_state_t;

  typedef enum logic [1:0] {NPC_SEQ, NPC_BPU, NPC_FLUSH, NPC_HOLD} npc_sel_t;

  // Fetch-group aligned address (8-byte groups).
  function automatic logic [31:0] fetch_align(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/ifu_pc_gen_tracker.sv
// Outstanding-request and squash tracker for I-cache fetch requests.
//   clk, rst        : clock, synchronous active-high reset
//   fire            : request accepted this cycle
//   flush           : backend redirect; all in-flight responses become stale
//   resp_valid      : response for the oldest outstanding request
//   outstanding     : accepted-but-unanswered request count (registered)
//   full_c          : outstanding has reached the cap
//   resp_discard_c  : current response belongs to a squashed request
module fetch_req_tracker
  import ifu_pc_gen_pkg::*;
#(
  parameter  int unsigned MAX_OUT = PCG_MAX_OUTSTANDING,
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic             flush,
  input  logic             resp_valid,
  output logic [CNT_W-1:0] outstanding,
  output logic             full_c,
  output logic             resp_discard_c
);

  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] drop_nxt;
  logic             resp_legal;

  // A response with nothing outstanding is ignored so the counter saturates at 0.
  always_comb begin
    resp_legal     = resp_valid && (outstanding != '0);
    full_c         = (outstanding == CNT_W'(MAX_OUT));
    resp_discard_c = !rst && resp_valid && (drop_cnt != '0);

    out_nxt = outstanding;
    if (fire && !resp_legal) begin
      out_nxt = outstanding + CNT_W'(1);
    end else if (!fire && resp_legal) begin
      out_nxt = outstanding - CNT_W'(1);
    end

    // On flush everything still in flight (minus a response leaving now) is stale.
    drop_nxt = drop_cnt;
    if (flush) begin
      drop_nxt = resp_legal ? (outstanding - CNT_W'(1)) : outstanding;
    end else if (resp_discard_c) begin
      drop_nxt = drop_cnt - CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
    end
  end

  resp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid && (outstanding == '0)));

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: holds the fetch PC, picks the next PC from backend flush,
// BPU redirect or sequential nPC, and issues fetch-group requests to the I-cache.
//   clk, rst                 : clock, synchronous active-high reset
//   if0_npc                  : sequential next PC from IF_0
//   stall                    : downstream cannot accept a new fetch group
//   bk_flush, bk_target      : backend redirect and its target
//   bpu_redirect, bpu_target : BPU predicted-taken redirect and its target
//   pc, pc_valid             : current fetch PC and its liveness
//   ic_req_valid/ready/addr  : I-cache request handshake and aligned address
//   ic_resp_valid            : I-cache response for the oldest request
//   ic_resp_discard          : current response belongs to a squashed request
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = PCG_RESET_PC,
  parameter int unsigned MAX_OUTSTANDING = PCG_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if0_npc,
  input  logic        stall,
  input  logic        bk_flush,
  input  logic [31:0] bk_target,
  input  logic        bpu_redirect,
  input  logic [31:0] bpu_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  output logic        ic_resp_discard
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  pcgen_state_t     state;
  pcgen_state_t     state_nxt;
  npc_sel_t         npc_sel;
  logic [31:0]      pc_nxt;
  logic [CNT_W-1:0] outstanding;
  logic             full;
  logic             fire;
  logic             blocked;

  fetch_req_tracker #(.MAX_OUT(MAX_OUTSTANDING)) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .fire           (fire),
    .flush          (bk_flush),
    .resp_valid     (ic_resp_valid),
    .outstanding    (outstanding),
    .full_c         (full),
    .resp_discard_c (ic_resp_discard)
  );

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PCG_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Request handshake, next state and next-PC selection.
  always_comb begin
    ic_req_valid = 1'b0;
    pc_valid     = 1'b0;
    fire         = 1'b0;
    ic_req_addr  = fetch_align(pc);
    state_nxt    = state;
    npc_sel      = NPC_HOLD;
    pc_nxt       = pc;

    ic_req_valid = !rst && (state == PCG_RUN) && !stall && !bk_flush && !full;
    pc_valid     = ic_req_valid;
    fire         = ic_req_valid && ic_req_ready;

    // A response arriving this cycle frees a slot, so it does not count as blocked.
    blocked = stall || (full && !ic_resp_valid);

    case (state)
      PCG_BOOT: state_nxt = PCG_RUN;
      PCG_RUN:  if (blocked) state_nxt = PCG_HOLD;
      PCG_HOLD: if (!blocked) state_nxt = PCG_RUN;
      default:  state_nxt = PCG_BOOT;
    endcase
    if (bk_flush) state_nxt = PCG_RUN;

    // An unfired BPU redirect is dropped; the BPU re-presents it.
    if (bk_flush)                  npc_sel = NPC_FLUSH;
    else if (fire && bpu_redirect) npc_sel = NPC_BPU;
    else if (fire)                 npc_sel = NPC_SEQ;
    else                           npc_sel = NPC_HOLD;

    case (npc_sel)
      NPC_FLUSH: pc_nxt = bk_target;
      NPC_BPU:   pc_nxt = bpu_target;
      NPC_SEQ:   pc_nxt = if0_npc;
      default:   pc_nxt = pc;
    endcase
  end

endmodule
